// File: rtl/data_unpack.sv
// Unpacks 64-bit activation words into a stream of 16-bit lanes, MSB lane first.
// A 2-entry {last, word} FIFO lets the next RAM word land while the head drains.
module data_unpack #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W*LANES-1:0]  in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W-1:0]        out_lane,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned WORD_W = DATA_W * LANES;

  logic [1:0]        r_count;
  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_word0;
  logic [WORD_W-1:0] r_word1;
  logic              r_last0;
  logic              r_last1;

  logic w_push;
  logic w_fire;
  logic w_lane_end;
  logic w_pop;

  assign w_push     = in_valid && in_ready;
  assign w_fire     = out_valid && out_ready;
  assign w_lane_end = (r_lane == LANE_W'(LANES - 1));
  assign w_pop      = w_fire && w_lane_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_lane  <= '0;
      r_word0 <= '0;
      r_word1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      if (w_fire) begin
        r_lane <= w_lane_end ? '0 : r_lane + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_word0 <= in_data;
            r_last0 <= in_last;
          end else begin
            r_word1 <= in_data;
            r_last1 <= in_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_word0 <= r_word1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        // Push with pop only happens at count 1 (in_ready is low at 2): new word is the head.
        2'b11: begin
          r_word0 <= in_data;
          r_last0 <= in_last;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane == LANE_W'(i)) begin
        out_data = r_word0[WORD_W-1-DATA_W*i -: DATA_W];
      end
    end
  end

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_lane  = r_lane;
  assign out_last  = out_valid && r_last0 && w_lane_end;
  assign busy      = (r_count != 2'd0);

endmodule

// File: tb/tb_data_unpack.sv
// Scoreboard bench for data_unpack: stimulus queues expected lanes, monitor checks each transfer.
module tb_data_unpack;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  lane;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  data_unpack #(
    .DATA_W(16),
    .LANES (4),
    .LANE_W(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane (out_lane),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted transfer is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_xfer: got data %0h lane %0d, expected no transfer",
                 out_data, out_lane);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer", {45'd0, out_data, out_lane, out_last}, {45'd0, e.data, e.lane, e.last});
      end
    end
  end

  // Drive one word; returns #1 after the edge that captured it.
  task automatic push(input logic [63:0] w, input logic last);
    int guard;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: in_ready 0, expected 1");
    end
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = w[63-16*i -: 16];
      e.lane = 2'(i);
      e.last = last && (i == 3);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    cycles(2);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_out_data", 64'(out_data), 64'd0);
    check("post_rst_out_lane", 64'(out_lane), 64'd0);
    check("post_rst_out_last", 64'(out_last), 64'd0);

    // Single word, free-flowing consumer.
    out_ready = 1'b1;
    push(64'h1111_2222_3333_4444, 1'b0);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("latency_data", 64'(out_data), 64'h1111);
    cycles(4);
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_busy", 64'(busy), 64'd0);

    // Backpressure at lane 2.
    out_ready = 1'b0;
    push(64'h1111_2222_3333_4444, 1'b0);
    out_ready = 1'b1;
    cycles(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_data", 64'(out_data), 64'h3333);
      check("hold_lane", 64'(out_lane), 64'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    cycles(3);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Two buffered words, last flag on the second.
    out_ready = 1'b0;
    push(64'hAAAA_0001_0002_0003, 1'b0);
    push(64'hBBBB_0004_0005_0006, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_bubble", 64'(out_valid), 64'd1);
      if (i == 0) check("full_in_ready_hold", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("ab_drained", 64'(out_valid), 64'd0);

    // Reset mid-stream with two words buffered, head at lane 1.
    out_ready = 1'b0;
    push(64'hAAAA_0001_0002_0003, 1'b0);
    push(64'hBBBB_0004_0005_0006, 1'b1);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("pre_rst_lane", 64'(out_lane), 64'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_lane", 64'(out_lane), 64'd0);
    cycles(2);
    rst = 1'b0;
    out_ready = 1'b1;
    push(64'h8000_7FFF_0000_FFFF, 1'b1);
    check("after_rst_lane0", 64'(out_lane), 64'd0);
    check("after_rst_data0", 64'(out_data), 64'h8000);
    cycles(5);
    check("final_out_valid", 64'(out_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
